// File: rtl/pope_rom_access_arbiter_if.sv
// Request/response/ROM bus for the pope ROM access arbiter.
// master = requesters + ROM side, slave = the arbiter.
interface pope_rom_access_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 48
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_data;

  modport master (
    output req_valid, req_addr, rom_data, resp_ready,
    input  req_ready, rom_addr, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_addr, rom_data, resp_ready,
    output req_ready, rom_addr, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/pope_rom_access_arbiter.sv
// Round-robin arbiter sharing one combinational pope ROM among NUM_REQ requesters.
// One lookup outstanding at a time: IDLE -> LOOKUP -> RESP -> IDLE.
module pope_rom_access_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned LOOKUP_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pope_rom_access_arbiter_if.slave bus,
  output logic                    busy
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               busy_q;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [31:0] idx;
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      rom_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rom_addr_q   <= rom_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rom_addr_d   = rom_addr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    req_ready_c  = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_c[winner] = 1'b1;
          rom_addr_d = addr_arr[winner];
          id_d       = winner;
          rr_ptr_d   = (32'(winner) + 32'd1 >= NUM_REQ) ? '0 : winner + ID_W'(1);
          cnt_d      = CNT_W'(LOOKUP_CYC - 1);
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cnt_q == '0) begin
          resp_data_d  = bus.rom_data;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Handshake cycle never accepts; the next grant waits for IDLE.
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_pope_rom_access_arbiter.sv
// Scoreboard bench for pope_rom_access_arbiter: grant order, response data/id/latency,
// stall stability, mid-transaction reset, and a LOOKUP_CYC=3 instance.
module tb_pope_rom_access_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 48;

  typedef struct {
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy3;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   grants_seen = 0;
  int   grant_q[$];
  exp_t exp_q[$];
  exp_t ae, re;
  bit   held = 1'b0;
  logic [1:0]    h_id;
  logic [DW-1:0] h_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pope_rom_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();
  pope_rom_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  pope_rom_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LOOKUP_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );
  pope_rom_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LOOKUP_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3)
  );

  // Bench ROM: arbitrary mix, bit 24 always 1, bit 30 always 0, bit 6 only at 0x3B.
  function automatic logic [DW-1:0] rom_model(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = {a, ~a, a ^ 6'h2A, {a[2:0], a[5:3]}, a, ~a, a ^ 6'h15, a};
    d[24] = 1'b1;
    d[30] = 1'b0;
    d[6]  = (a == 6'h3B);
    return d;
  endfunction

  assign bus.rom_data  = rom_model(bus.rom_addr);
  assign bus3.rom_data = rom_model(bus3.rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor: compares req_ready with the expected winner and queues the response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        chk("req_ready_while_busy", 64'(bus.req_ready), 64'd0);
      end else if (bus.req_valid != '0) begin
        if (grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant_opportunity: req_ready %b", bus.req_ready);
        end else begin
          int g;
          g = grant_q.pop_front();
          chk("grant", 64'(bus.req_ready), 64'd1 << g);
          ae.id   = 2'(g);
          ae.addr = bus.req_addr[g*AW +: AW];
          ae.data = rom_model(ae.addr);
          ae.due  = cyc + 2;
          exp_q.push_back(ae);
          grants_seen++;
        end
      end
    end
  end

  // Response monitor: latency on first sight, stability while stalled, payload at handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_response: id %0d data %0h", bus.resp_id, bus.resp_data);
      end else begin
        re = exp_q[0];
        if (!held) begin
          chk("resp_latency", 64'(cyc), 64'(re.due));
        end else begin
          chk("resp_id_stable", 64'(bus.resp_id), 64'(h_id));
          chk("resp_data_stable", 64'(bus.resp_data), 64'(h_data));
        end
        if (bus.resp_ready) begin
          chk("resp_id", 64'(bus.resp_id), 64'(re.id));
          chk("resp_data", 64'(bus.resp_data), 64'(re.data));
          chk("resp_bits_6_24_30", 64'({bus.resp_data[6], bus.resp_data[24], bus.resp_data[30]}),
              64'({(re.addr == 6'h3B), 1'b1, 1'b0}));
          void'(exp_q.pop_front());
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_id   = bus.resp_id;
          h_data = bus.resp_data;
        end
      end
    end
  end

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    grant_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns just after the accept edge (DUT in its first LOOKUP cycle).
  task automatic wait_grants(input int target, input string name);
    int n = 0;
    while (grants_seen < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (grants_seen < target) begin
      errors++;
      $display("FAIL %s_timeout: grants %0d expected %0d", name, grants_seen, target);
    end
  endtask

  task automatic wait_resp_valid(input string name);
    int n = 0;
    while (!bus.resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_resp_valid"}, 64'(bus.resp_valid), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({name, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
    chk({name, "_resp_id"}, 64'(bus.resp_id), 64'd0);
    chk({name, "_resp_data"}, 64'(bus.resp_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.resp_ready  = 1'b1;
    bus3.req_valid  = '0;
    bus3.req_addr   = '0;
    bus3.resp_ready = 1'b1;

    do_reset();
    chk_reset_outputs("reset");
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);

    // Single request from requester 0 at 0x3B.
    set_addr(0, 6'h3B);
    bus.req_valid = 4'b0001;
    grant_q.push_back(0);
    wait_grants(grants_seen + 1, "t1");
    bus.req_valid = '0;
    wait_drain("t1");

    // All requesters held: 0,1,2,3,0.
    do_reset();
    set_addr(0, 6'h01); set_addr(1, 6'h12); set_addr(2, 6'h23); set_addr(3, 6'h3F);
    foreach (grant_q[i]) grant_q.delete(i);
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    grant_q.push_back(3); grant_q.push_back(0);
    tgt = grants_seen + 5;
    bus.req_valid = 4'b1111;
    wait_grants(tgt, "t2");
    bus.req_valid = '0;
    wait_drain("t2");

    // Stall RESP for 5 cycles; rr_ptr is 1 here.
    bus.resp_ready = 1'b0;
    set_addr(1, 6'h2A);
    bus.req_valid = 4'b0010;
    grant_q.push_back(1);
    wait_grants(grants_seen + 1, "t3");
    bus.req_valid = '0;
    wait_resp_valid("t3");
    repeat (5) @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_idle_after_handshake", 64'({busy, bus.resp_valid}), 64'd0);
    wait_drain("t3");

    // Reset during LOOKUP.
    set_addr(3, 6'h11);
    bus.req_valid = 4'b1000;
    grant_q.push_back(3);
    wait_grants(grants_seen + 1, "t5a");
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_lookup_reset");
    exp_q.delete();
    grant_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // After reset rr_ptr=0: requester 0 wins over 3; then reset during RESP.
    bus.resp_ready = 1'b0;
    set_addr(0, 6'h07);
    bus.req_valid = 4'b1001;
    grant_q.push_back(0);
    wait_grants(grants_seen + 1, "t5b");
    bus.req_valid = '0;
    wait_resp_valid("t5b");
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_resp_reset");
    exp_q.delete();
    grant_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_stale_resp", 64'(bus.resp_valid), 64'd0);
    set_addr(0, 6'h08); set_addr(1, 6'h09);
    bus.req_valid = 4'b0011;
    grant_q.push_back(0);
    wait_grants(grants_seen + 1, "t5c");
    bus.req_valid = '0;
    wait_drain("t5c");

    // Sweep all addresses through requester 2.
    for (int a = 0; a < 64; a++) begin
      set_addr(2, 6'(a));
      bus.req_valid = 4'b0100;
      grant_q.push_back(2);
      wait_grants(grants_seen + 1, "t6");
    end
    bus.req_valid = '0;
    wait_drain("t6");

    // LOOKUP_CYC=3 instance: addr held 3 cycles, resp 4 cycles after accept.
    bus3.req_addr[1*AW +: AW] = 6'h15;
    bus3.req_valid = 4'b0010;
    @(negedge clk);
    chk("t4_grant", 64'(bus3.req_ready), 64'b0010);
    @(posedge clk); #1;
    bus3.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_rom_addr_held", 64'(bus3.rom_addr), 64'h15);
      chk("t4_no_early_resp", 64'(bus3.resp_valid), 64'd0);
      chk("t4_busy", 64'(busy3), 64'd1);
    end
    @(negedge clk);
    chk("t4_resp_valid", 64'(bus3.resp_valid), 64'd1);
    chk("t4_resp_id", 64'(bus3.resp_id), 64'd1);
    chk("t4_resp_data", 64'(bus3.resp_data), 64'(rom_model(6'h15)));
    @(posedge clk); #1;
    chk("t4_idle", 64'({busy3, bus3.resp_valid}), 64'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
